mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive I-port denials before I-port is forced priority; range 1..7.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 sync_rst  in  1  reset; synchronous, active-low.
REQ-006 clk_en  in  1  global enable; low freezes all state and blocks new grants.
REQ-007 i_req  in  1; i_addr  in  ADDR_W  instruction-fetch read request and address.
REQ-008 i_gnt  out  1; i_rvalid  out  1; i_rdata  out  DATA_W  fetch accept, read-response valid, read data.
REQ-009 d_req  in  1; d_we  in  1; d_be  in  DATA_W/8; d_addr  in  ADDR_W; d_wdata  in  DATA_W  load/store request.
REQ-010 d_gnt  out  1; d_rvalid  out  1; d_rdata  out  DATA_W  load/store accept, response valid (reads and writes), read data.
REQ-011 m_req  out  1; m_we  out  1; m_be  out  DATA_W/8; m_addr  out  ADDR_W; m_wdata  out  DATA_W  shared memory port request.
REQ-012 m_rdata  in  DATA_W  memory read data, valid exactly one enabled cycle after an accepted m_req; memory always accepts.

Function
REQ-013 Arbitration is combinational per cycle: a request with req=1 is accepted in the same cycle its gnt=1; a requester holds req and payload until gnt.
REQ-014 With clk_en=1 and only one requester active, that requester is granted.
REQ-015 With both active, D-port wins unless starve_cnt == STARVE_LIMIT, in which case I-port wins.
REQ-016 starve_cnt (3-bit register): increments when i_req=1 and d_gnt=1 while clk_en=1; clears to 0 when i_gnt=1 or i_req=0 (with clk_en=1); never exceeds STARVE_LIMIT.
REQ-017 At most one of i_gnt, d_gnt is 1 in any cycle; m_req = i_gnt | d_gnt.
REQ-018 On i_gnt: m_addr=i_addr, m_we=0, m_be=all ones, m_wdata=0; on d_gnt: m_* driven from d_*; with no grant m_we=0, m_be=0, m_addr=0, m_wdata=0.
REQ-019 Response tag register rsp_sel in {NONE, I, D}: on an enabled cycle loads I if i_gnt, D if d_gnt, else NONE.
REQ-020 Response latency is exactly one enabled cycle: i_rvalid = (rsp_sel==I) & clk_en; d_rvalid = (rsp_sel==D) & clk_en.
REQ-021 i_rdata and d_rdata both equal m_rdata combinationally; consumers qualify with their rvalid.
REQ-022 A D-port write produces d_rvalid one cycle after d_gnt (write acknowledge); d_rdata is don't-care then.
REQ-023 Back-to-back grants are allowed every cycle; a new grant and the previous request's rvalid coexist in the same cycle.
REQ-024 clk_en=0: i_gnt=d_gnt=m_req=0, rvalids=0, rsp_sel and starve_cnt hold; the pending response is delivered on the next cycle with clk_en=1, provided memory holds m_rdata while disabled.
REQ-025 Address and data are passed unmodified; no alignment checking or byte-lane shifting.

Reset
REQ-026 While sync_rst=0 at a rising edge: rsp_sel<=NONE, starve_cnt<=0.
REQ-027 During reset cycles all gnt, rvalid, and m_req outputs are 0, regardless of req inputs.
REQ-028 Reset asserted with a response pending discards it: no rvalid is produced in the first cycle after reset release.

Verification
REQ-029 Single fetch: i_req=1, i_addr=0x100 one cycle -> i_gnt=1, m_addr=0x100, m_we=0, m_be=0xF; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-030 Store: d_req=1, d_we=1, d_be=0x3, d_addr=0x2004, d_wdata=0xDEADBEEF -> d_gnt=1, m_* matches; next cycle d_rvalid=1, i_rvalid=0.
REQ-031 Contention, STARVE_LIMIT=3, i_req and d_req held high continuously -> grant sequence D,D,D,I,D,D,D,I...; every response tag matches its grant.
REQ-032 clk_en dropped for 2 cycles immediately after an i_gnt -> no rvalid while low; i_rvalid=1 on the first re-enabled cycle with held m_rdata; starve_cnt unchanged.
REQ-033 sync_rst=0 in the cycle after d_gnt (read) -> d_rvalid stays 0 through and after reset; starve_cnt=0 on release.
REQ-034 Random bench with a one-cycle-latency memory model and 10k cycles -> each requester receives exactly one rvalid per grant, in order, with the correct data; i_gnt & d_gnt never both 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-cycle-latency memory port.
// The data port normally has priority; the fetch port is forced through
// after STARVE_LIMIT consecutive denials. A response tag register routes
// each returning read (or write acknowledge) to the port that was granted.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  clk_en,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int         BE_W  = DATA_W / 8;
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_sel_t;

    rsp_sel_t   r_rsp_sel;
    rsp_sel_t   w_rsp_sel_next;
    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_next;

    logic       w_active;
    logic       w_force_i;
    logic       w_i_gnt;
    logic       w_d_gnt;

    // Grants are suppressed both while disabled and while reset is held.
    assign w_active  = clk_en & sync_rst;
    assign w_force_i = (r_starve_cnt == LIMIT);

    // Per-cycle arbitration: D wins ties unless the fetch port is starving.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (w_active) begin
            if (i_req && (!d_req || w_force_i)) begin
                w_i_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // Starvation counter: counts fetch denials, cleared when fetch is served or idle.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_active) begin
            if (w_i_gnt || !i_req) begin
                w_starve_next = 3'd0;
            end else if (w_d_gnt && (r_starve_cnt != LIMIT)) begin
                w_starve_next = r_starve_cnt + 3'd1;
            end
        end
    end

    // Response tag next state: remember who owns next cycle's memory data.
    always_comb begin
        w_rsp_sel_next = r_rsp_sel;
        if (w_active) begin
            if (w_i_gnt) begin
                w_rsp_sel_next = RSP_I;
            end else if (w_d_gnt) begin
                w_rsp_sel_next = RSP_D;
            end else begin
                w_rsp_sel_next = RSP_NONE;
            end
        end
    end

    // State register; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            r_rsp_sel    <= RSP_NONE;
            r_starve_cnt <= 3'd0;
        end else begin
            r_rsp_sel    <= w_rsp_sel_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Shared memory port mux; idle port drives zeros.
    always_comb begin
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_i_gnt) begin
            m_be   = {BE_W{1'b1}};
            m_addr = i_addr;
        end else if (w_d_gnt) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign m_req    = w_i_gnt | w_d_gnt;

    // A pending response is only presented on an enabled, non-reset cycle.
    assign i_rvalid = (r_rsp_sel == RSP_I) & w_active;
    assign d_rvalid = (r_rsp_sel == RSP_D) & w_active;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention pattern,
// clock-enable freeze and reset-discard scenarios.
module tb_mem_port_arbiter;

    localparam logic [31:0] KEY = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        sync_rst, clk_en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one enabled cycle of latency, data = address ^ KEY, held while idle.
    always @(posedge clk) begin
        if (clk_en && m_req) m_rdata <= m_addr ^ KEY;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat_i;
        pat_i = 8'b1000_1000;   // bit k = 1 -> I-port granted in contention cycle k

        // Reset held with both requests active
        sync_rst = 1'b0; clk_en = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h0;
        for (int r = 0; r < 2; r++) begin
            mid();
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_m_req", m_req, 0);
            chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
            $display("reset cycle %0d: i_gnt=%0b d_gnt=%0b m_req=%0b", r, i_gnt, d_gnt, m_req);
            cyc();
        end

        // Single fetch of 0x100
        sync_rst = 1'b1; i_addr = 32'h100; d_req = 1'b0;
        mid();
        chk("fetch_starve0", dut.r_starve_cnt, 0);
        chk("fetch_i_gnt", i_gnt, 1);
        chk("fetch_d_gnt", d_gnt, 0);
        chk("fetch_m_req", m_req, 1);
        chk("fetch_m_addr", m_addr, 32'h100);
        chk("fetch_m_we", m_we, 0);
        chk("fetch_m_be", m_be, 4'hF);
        chk("fetch_m_wdata", m_wdata, 0);
        chk("fetch_no_rvalid", {i_rvalid, d_rvalid}, 0);
        $display("fetch: i_gnt=%0b m_addr=0x%0h m_be=0x%0h", i_gnt, m_addr, m_be);

        // Store issued in the same cycle the fetch response returns
        cyc();
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        mid();
        chk("fetch_i_rvalid", i_rvalid, 1);
        chk("fetch_i_rdata", i_rdata, 32'hCAFE0100);
        chk("store_d_gnt", d_gnt, 1);
        chk("store_i_gnt", i_gnt, 0);
        chk("store_m_we", m_we, 1);
        chk("store_m_be", m_be, 4'h3);
        chk("store_m_addr", m_addr, 32'h2004);
        chk("store_m_wdata", m_wdata, 32'hDEADBEEF);
        $display("store: d_gnt=%0b i_rvalid=%0b i_rdata=0x%0h", d_gnt, i_rvalid, i_rdata);

        // Store acknowledge, idle port
        cyc();
        d_req = 1'b0;
        mid();
        chk("store_d_rvalid", d_rvalid, 1);
        chk("store_ack_i_rvalid", i_rvalid, 0);
        chk("idle_m_req", m_req, 0);
        chk("idle_m_be", m_be, 0);
        chk("idle_m_addr", m_addr, 0);
        chk("idle_m_we", m_we, 0);
        $display("store ack: d_rvalid=%0b i_rvalid=%0b", d_rvalid, i_rvalid);

        // Contention: D,D,D,I,D,D,D,I
        cyc();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            mid();
            chk("cont_starve", dut.r_starve_cnt, k % 4);
            chk("cont_i_gnt", i_gnt, pat_i[k]);
            chk("cont_d_gnt", d_gnt, !pat_i[k]);
            chk("cont_m_addr", m_addr, pat_i[k] ? 32'h40 : 32'h80);
            if (k == 0) begin
                chk("cont_rvalid0", {i_rvalid, d_rvalid}, 0);
            end else begin
                chk("cont_i_rvalid", i_rvalid, pat_i[k-1]);
                chk("cont_d_rvalid", d_rvalid, !pat_i[k-1]);
                chk("cont_rdata", d_rdata, pat_i[k-1] ? 32'hCAFE0040 : 32'hCAFE0080);
            end
            $display("contention %0d: i_gnt=%0b d_gnt=%0b i_rvalid=%0b d_rvalid=%0b", k, i_gnt, d_gnt, i_rvalid, d_rvalid);
        end

        // Fetch 0x300, then clk_en low for two cycles
        cyc();
        d_req = 1'b0; i_addr = 32'h300;
        mid();
        chk("pre_en_i_gnt", i_gnt, 1);
        chk("pre_en_i_rvalid", i_rvalid, 1);
        chk("pre_en_i_rdata", i_rdata, 32'hCAFE0040);
        $display("fetch before disable: i_gnt=%0b i_rvalid=%0b", i_gnt, i_rvalid);
        for (int e = 0; e < 2; e++) begin
            cyc();
            clk_en = 1'b0; i_req = 1'b1; d_req = 1'b1;
            mid();
            chk("dis_gnt", {i_gnt, d_gnt}, 0);
            chk("dis_m_req", m_req, 0);
            chk("dis_rvalid", {i_rvalid, d_rvalid}, 0);
            chk("dis_starve", dut.r_starve_cnt, 0);
            $display("disabled %0d: gnt=%0b%0b rvalid=%0b%0b", e, i_gnt, d_gnt, i_rvalid, d_rvalid);
        end
        cyc();
        clk_en = 1'b1; i_req = 1'b0; d_req = 1'b0;
        mid();
        chk("reen_i_rvalid", i_rvalid, 1);
        chk("reen_i_rdata", i_rdata, 32'hCAFE0300);
        chk("reen_d_rvalid", d_rvalid, 0);
        chk("reen_starve", dut.r_starve_cnt, 0);
        $display("re-enabled: i_rvalid=%0b i_rdata=0x%0h", i_rvalid, i_rdata);

        // D read granted over I, then reset discards its response
        cyc();
        i_req = 1'b1; i_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        mid();
        chk("rd_d_gnt", d_gnt, 1);
        chk("rd_i_gnt", i_gnt, 0);
        chk("rd_m_addr", m_addr, 32'h500);
        $display("read before reset: d_gnt=%0b m_addr=0x%0h", d_gnt, m_addr);
        cyc();
        sync_rst = 1'b0;
        mid();
        chk("rstp_d_rvalid", d_rvalid, 0);
        chk("rstp_gnt", {i_gnt, d_gnt}, 0);
        chk("rstp_m_req", m_req, 0);
        chk("rstp_starve", dut.r_starve_cnt, 1);
        $display("reset with pending read: d_rvalid=%0b", d_rvalid);
        cyc();
        sync_rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        mid();
        chk("post_rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("post_rst_starve", dut.r_starve_cnt, 0);
        $display("after reset release: i_rvalid=%0b d_rvalid=%0b", i_rvalid, d_rvalid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
